data_memory_bank: RTL and testbench
===================================

Name: data_memory_bank

Overview:
Parametrised word/byte-addressable data memory for the ARM datapath. It is the successor to the single-width RAM and adds four features:
- byte-lane stores and loads, with sign or zero extension on byte loads
- a registered read port
- alignment and range fault detection
- a hardware clear sequencer run after reset

It sits between the execute stage's ALU result and the writeback mux.

Parameters:
DEPTH, 64, number of 32-bit words (power of two, >= 4)
ADDR_WIDTH, 32, width of the byte address input
CLEAR_ON_RESET, 1, when 1 the sequencer zeroes every word after reset; when 0 the memory contents are left untouched

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
write_enable  input  1  store request this cycle
byte_mode  input  1  0 = 32-bit word access, 1 = 8-bit byte access
sign_extend  input  1  byte loads only: 1 = sign-extend, 0 = zero-extend
address  input  ADDR_WIDTH  byte address
data_input  input  32  store data; byte stores use bits [7:0]
data_output  output  32  registered load data
busy  output  1  high while resetting or clearing; accesses ignored
fault  output  1  registered; high for the cycle after a faulting access

Behaviour:
- Reset is synchronous and active-high: rst sampled high at a clk edge forces these values:
  - state = CLEAR if CLEAR_ON_RESET is 1, else READY_WAIT
  - clear_ptr = 0, busy = 1, data_output = 0, fault = 0
- Holding rst high keeps the block in this condition indefinitely.
- FSM states:
  - CLEAR: each edge with rst low writes 0 to mem[clear_ptr] and increments clear_ptr. On the edge that clears word DEPTH-1, go to READY and drop busy. The first READY cycle is DEPTH edges after rst deasserts.
  - READY_WAIT (CLEAR_ON_RESET = 0): one edge, then READY with busy = 0.
  - READY: normal accesses.
- rst asserted mid-clear or mid-operation: restart at CLEAR with clear_ptr = 0. An in-flight write on that edge is dropped.
- While busy = 1: write_enable ignored, data_output held at 0, fault = 0.
- Addressing:
  - word index = address[log2(DEPTH)+1:2]
  - lane = address[1:0]; lane 0 = bits [7:0] (little-endian)
  - Range fault: address >= 4*DEPTH.
  - Alignment fault: byte_mode = 0 and lane != 0.
  - On any fault: write suppressed, data_output <= 0, fault <= 1, memory unchanged.
- Write (READY, write_enable = 1, no fault), at the edge:
  - word mode: mem[idx] <= data_input
  - byte mode: only lane bits replaced by data_input[7:0]; other lanes unchanged
- Read (READY, every cycle, no fault): data_output updates at the edge, one-cycle latency.
  - word mode: mem[idx]
  - byte mode: the selected lane, extended per sign_extend
- Read-during-write to the same word is read-first: data_output shows the pre-write contents, and the new data is visible one cycle later.
- fault is a one-cycle pulse per faulting access. Back-to-back faulting cycles hold fault high.
- Any value of address with busy = 0 never produces X on data_output.

Test Plan:
1. Clear sequence (CLEAR_ON_RESET = 1, DEPTH = 64):
   - Stimulus: rst high for 2 cycles, release.
   - Required: busy stays high for exactly 64 edges, then low. A word read of every address 0x00..0xFC returns 0x00000000, including a word pre-written before reset.
2. Word store and load:
   - Stimulus: write 0x0000FA32 to 0x4, then write_enable = 0 at 0x4.
   - Required: data_output = 0x0000FA32 one cycle after the read is presented. A same-cycle write of 0xEA99 to 0x4 followed by a read shows 0x0000FA32 first, 0x0000EA99 next (read-first).
3. Byte lanes:
   - Stimulus: word write 0x11223344 to 0x8; byte write 0xF0 to 0xA.
   - Required: word read of 0x8 returns 0x11F03344. Byte read of 0xA with sign_extend = 1 returns 0xFFFFFFF0; with sign_extend = 0 returns 0x000000F0.
4. Faults:
   - Stimulus: word write to 0x6; then any access to 0x100 (DEPTH = 64).
   - Required: fault pulses high each time, data_output = 0, and a subsequent word read of 0x4 shows its prior contents unchanged.
5. Reset mid-clear:
   - Stimulus: assert rst at clear_ptr = 30, release.
   - Required: busy lasts a full 64 further edges and all words read 0.
6. CLEAR_ON_RESET = 0:
   - Stimulus: write 0xDEADBEEF to 0x0; pulse rst.
   - Required: busy low 1 edge after release; reading 0x0 returns 0xDEADBEEF.

Source files
------------

// File: rtl/data_memory_bank.sv
// Word/byte-addressable data memory with registered read port, fault detection and post-reset clear.
// Loads have one-cycle latency and are read-first; busy blocks all accesses while clearing.
module data_memory_bank #(
    parameter int DEPTH          = 64,
    parameter int ADDR_WIDTH     = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable,
    input  logic                  byte_mode,
    input  logic                  sign_extend,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           data_input,
    output logic [31:0]           data_output,
    output logic                  busy,
    output logic                  fault
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_CLEAR      = 2'd0,
        S_READY_WAIT = 2'd1,
        S_READY      = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] clear_ptr_q, clear_ptr_d;
    logic [31:0]      data_output_q, data_output_d;
    logic             fault_q, fault_d;

    logic [31:0]      mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             range_fault, align_fault, access_fault, ready;
    logic [31:0]      rd_word;
    logic [7:0]       lane_byte;

    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [31:0]      mem_wdata;

    assign idx          = address[IDX_W+1:2];
    assign lane         = address[1:0];
    assign range_fault  = (address >> (IDX_W + 2)) != '0;
    assign align_fault  = !byte_mode && (lane != 2'd0);
    assign access_fault = range_fault || align_fault;
    assign ready        = (state_q == S_READY);
    assign rd_word      = mem[idx];
    assign lane_byte    = rd_word[{lane, 3'b000} +: 8];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY_WAIT;
            clear_ptr_q   <= '0;
            data_output_q <= '0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            clear_ptr_q   <= clear_ptr_d;
            data_output_q <= data_output_d;
            fault_q       <= fault_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        case (state_q)
            S_CLEAR: begin
                clear_ptr_d = clear_ptr_q + 1'b1;
                if (clear_ptr_q == IDX_W'(DEPTH - 1)) state_d = S_READY;
            end
            S_READY_WAIT: state_d = S_READY;
            S_READY:      state_d = S_READY;
            default:      state_d = S_CLEAR;
        endcase
    end

    // Output and memory-port logic
    always_comb begin
        busy          = !ready;
        mem_we        = 1'b0;
        mem_waddr     = idx;
        mem_wdata     = data_input;
        data_output_d = '0;
        fault_d       = 1'b0;
        if (state_q == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clear_ptr_q;
            mem_wdata = '0;
        end else if (ready) begin
            if (access_fault) begin
                fault_d = 1'b1;
            end else begin
                mem_we = write_enable;
                if (byte_mode) begin
                    mem_wdata                       = rd_word;
                    mem_wdata[{lane, 3'b000} +: 8]  = data_input[7:0];
                    data_output_d = {{24{sign_extend & lane_byte[7]}}, lane_byte};
                end else begin
                    data_output_d = rd_word;
                end
            end
        end
    end

    // Memory contents are deliberately not reset; a write coinciding with rst is dropped.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign data_output = data_output_q;
    assign fault       = fault_q;
endmodule

// File: tb/tb_data_memory_bank.sv
// Directed bench: clear-on-reset instance (dut) and no-clear instance (dut0) share all inputs.
module tb_data_memory_bank;
    logic        clk = 1'b0;
    logic        rst;
    logic        write_enable, byte_mode, sign_extend;
    logic [31:0] address, data_input;
    logic [31:0] dout, dout0;
    logic        busy, busy0, fault, fault0;
    int          vectors = 0;
    int          miscompares = 0;
    int          n;

    always #5 clk = ~clk;

    data_memory_bank #(.DEPTH(64), .ADDR_WIDTH(32), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst(rst), .write_enable(write_enable), .byte_mode(byte_mode),
        .sign_extend(sign_extend), .address(address), .data_input(data_input),
        .data_output(dout), .busy(busy), .fault(fault)
    );

    data_memory_bank #(.DEPTH(64), .ADDR_WIDTH(32), .CLEAR_ON_RESET(0)) dut0 (
        .clk(clk), .rst(rst), .write_enable(write_enable), .byte_mode(byte_mode),
        .sign_extend(sign_extend), .address(address), .data_input(data_input),
        .data_output(dout0), .busy(busy0), .fault(fault0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic we, input logic bm, input logic se,
                      input logic [31:0] a, input logic [31:0] d);
        write_enable = we;
        byte_mode    = bm;
        sign_extend  = se;
        address      = a;
        data_input   = d;
        tick();
    endtask

    // Releases rst and counts edges until dut busy drops (bounded).
    task automatic release_and_count(input string tag);
        rst = 1'b0;
        n   = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 200);
        check(tag, n, 64);
    endtask

    initial begin
        rst = 1'b1;
        write_enable = 1'b0; byte_mode = 1'b0; sign_extend = 1'b0;
        address = '0; data_input = '0;
        tick(); tick();
        check("rst_busy",  {31'd0, busy},  1);
        check("rst_dout",  dout,           0);
        check("rst_fault", {31'd0, fault}, 0);
        check("rst_busy0", {31'd0, busy0}, 1);
        release_and_count("clear_len_first");

        // Test 1: pre-write a word, reset, verify clear length and all-zero contents
        op(1'b1, 1'b0, 1'b0, 32'h0, 32'h12345678);
        op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("prewrite_read", dout, 32'h12345678);
        rst = 1'b1;
        tick(); tick();
        check("rst2_dout", dout, 0);
        release_and_count("clear_len");
        for (int a = 0; a < 256; a += 4) begin
            op(1'b0, 1'b0, 1'b0, a, 32'h0);
            check($sformatf("clear_rd_%02h", a), dout, 0);
        end

        // Test 2: word store/load and read-first
        op(1'b1, 1'b0, 1'b0, 32'h4, 32'h0000FA32);
        op(1'b0, 1'b0, 1'b0, 32'h4, 32'h0);
        check("word_rd", dout, 32'h0000FA32);
        op(1'b1, 1'b0, 1'b0, 32'h4, 32'h0000EA99);
        check("rdw_old", dout, 32'h0000FA32);
        op(1'b0, 1'b0, 1'b0, 32'h4, 32'h0);
        check("rdw_new", dout, 32'h0000EA99);

        // Test 3: byte lanes
        op(1'b1, 1'b0, 1'b0, 32'h8, 32'h11223344);
        op(1'b1, 1'b1, 1'b0, 32'hA, 32'hABCDEFF0);
        op(1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
        check("byte_merge", dout, 32'h11F03344);
        op(1'b0, 1'b1, 1'b1, 32'hA, 32'h0);
        check("byte_sx", dout, 32'hFFFFFFF0);
        op(1'b0, 1'b1, 1'b0, 32'hA, 32'h0);
        check("byte_zx", dout, 32'h000000F0);
        op(1'b0, 1'b1, 1'b1, 32'h8, 32'h0);
        check("byte_l0", dout, 32'h00000044);
        op(1'b0, 1'b1, 1'b1, 32'hB, 32'h0);
        check("byte_l3", dout, 32'h00000011);
        check("nofault", {31'd0, fault}, 0);

        // Test 4: faults
        op(1'b1, 1'b0, 1'b0, 32'h6, 32'hBAADF00D);
        check("align_fault", {31'd0, fault}, 1);
        check("align_dout", dout, 0);
        op(1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
        check("range_fault_b2b", {31'd0, fault}, 1);
        check("range_dout", dout, 0);
        op(1'b1, 1'b1, 1'b0, 32'h104, 32'h55);
        check("range_byte_fault", {31'd0, fault}, 1);
        op(1'b0, 1'b0, 1'b0, 32'h4, 32'h0);
        check("fault_clear", {31'd0, fault}, 0);
        check("unchanged_4", dout, 32'h0000EA99);
        op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("unchanged_0", dout, 0);

        // Test 5: reset at clear_ptr = 30 restarts a full clear
        op(1'b1, 1'b0, 1'b0, 32'hFC, 32'hCAFEF00D);
        op(1'b0, 1'b0, 1'b0, 32'hFC, 32'h0);
        check("fc_written", dout, 32'hCAFEF00D);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("midclear_busy", {31'd0, busy}, 1);
        rst = 1'b1;
        tick();
        release_and_count("clear_len_restart");
        op(1'b0, 1'b0, 1'b0, 32'hFC, 32'h0);
        check("restart_fc", dout, 0);
        op(1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
        check("restart_8", dout, 0);

        // Test 6: no-clear instance keeps contents across reset
        op(1'b1, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF);
        rst = 1'b1;
        write_enable = 1'b0;
        tick();
        check("nc_rst_busy", {31'd0, busy0}, 1);
        rst = 1'b0;
        tick();
        check("nc_busy_low", {31'd0, busy0}, 0);
        check("c_busy_high", {31'd0, busy}, 1);
        op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("nc_keep", dout0, 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
